// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Contents: FSM state encoding, port-mux select values, default timeout.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GNT_IF = 2'd1;
  localparam logic [1:0] ST_GNT_DM = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GNT_IF = ST_GNT_IF,
    GNT_DM = ST_GNT_DM
  } arb_state_e;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  localparam int unsigned TIMEOUT_DEF = 64;

endpackage

// File: rtl/mem_arb_wdog.sv
// Grant watchdog: counts wait cycles of an outstanding memory grant.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr_i       clear count (held while no grant is outstanding)
//   en_i        count one more wait cycle
//   expire_c_o  combinational: this wait cycle brings the count to TIMEOUT-1
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Abort is decided on the wait cycle whose increment would reach TIMEOUT-1.
  assign expire_c_o = en_i & (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between IF (fetch) and MEM (load/store).
// Fixed priority DM > IF; one access at a time over a mem_req/mem_ready handshake.
// Ports:
//   if_req/if_addr -> if_rdata/if_ack          fetch requester
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ack  data requester
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready  memory side
//   addr_sel   external 2:1 mux select (0=IF, 1=DM)
//   stall_if, stall_mem  combinational pipeline stalls
//   bus_err    sticky timeout flag, cleared only by rst
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              addr_sel,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err
);

  arb_state_e        state_q;
  logic              wd_clr;
  logic              wd_en;
  logic              expire_c;
  logic              done_c;
  logic [DATA_W-1:0] rdata_c;

  // Watchdog runs only while a grant waits for mem_ready.
  assign wd_clr = (state_q == IDLE);
  assign wd_en  = (state_q != IDLE) & ~mem_ready;

  mem_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expire_c_o(expire_c)
  );

  // A grant ends on memory completion or on timeout; aborts return zero data.
  assign done_c  = mem_ready | expire_c;
  assign rdata_c = mem_ready ? mem_rdata : '0;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

  // Arbiter FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr_sel  <= SEL_IF;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          // A port whose ack is showing still holds req; masking it avoids a re-grant.
          if (dm_req && !dm_ack) begin
            state_q   <= GNT_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            addr_sel  <= SEL_DM;
          end else if (if_req && !if_ack) begin
            state_q  <= GNT_IF;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            addr_sel <= SEL_IF;
          end
        end
        GNT_IF, GNT_DM: begin
          if (done_c) begin
            state_q <= IDLE;
            mem_req <= 1'b0;
            if (!mem_ready) begin
              bus_err <= 1'b1;
            end
            if (state_q == GNT_DM) begin
              dm_rdata <= rdata_c;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= rdata_c;
              if_ack   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, ack scoreboard.
module tb_mem_port_arbiter;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              addr_sel;
  logic              stall_if;
  logic              stall_mem;
  logic              bus_err;

  mem_port_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .addr_sel (addr_sel),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory model: ready after wait_cfg wait cycles of a continuous mem_req.
  logic        mdl_ready   = 1'b0;
  logic [31:0] mdl_rdata   = 32'hDEAD_BEEF;
  logic        stray_ready = 1'b0;
  logic        ready_en    = 1'b1;
  int          wait_cfg    = 0;
  int          wcnt        = 0;

  assign mem_ready = mdl_ready | stray_ready;
  assign mem_rdata = mdl_rdata;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2008_0005;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (mem_req && ready_en) begin
      if (wcnt == wait_cfg) begin
        mdl_ready = 1'b1;
        mdl_rdata = mem_data(mem_addr);
        wcnt      = 0;
      end else begin
        mdl_ready = 1'b0;
        mdl_rdata = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      mdl_ready = 1'b0;
      mdl_rdata = 32'hDEAD_BEEF;
      wcnt      = 0;
    end
  end

  // Scoreboard monitor: every ack pulse must match the next expected completion.
  always @(negedge clk) begin
    if (if_ack || dm_ack) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b, required no ack at %0t",
                 if_ack, dm_ack, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ack_port_dm", 32'(dm_ack), 32'(e.is_dm));
        chk("ack_port_if", 32'(if_ack), 32'(!e.is_dm));
        chk("ack_rdata", dm_ack ? dm_rdata : if_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0;
    tick(); tick();
    // Reset values
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_addr_sel", 32'(addr_sel), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    rst = 1'b0;
    tick();

    // 1: single fetch, ready on first grant cycle
    if_req = 1'b1; if_addr = 32'h0000_0040;
    sb_q.push_back('{1'b0, 32'h2008_0005});
    tick();
    chk("t1_mem_req", 32'(mem_req), 1);
    chk("t1_addr_sel", 32'(addr_sel), 0);
    chk("t1_mem_addr", mem_addr, 32'h40);
    chk("t1_mem_we", 32'(mem_we), 0);
    chk("t1_stall_if", 32'(stall_if), 1);
    tick();
    chk("t1_if_ack", 32'(if_ack), 1);
    chk("t1_if_rdata", if_rdata, 32'h2008_0005);
    chk("t1_stall_if_ack", 32'(stall_if), 0);
    tick();
    if_req = 1'b0;
    chk("t1_no_regrant", 32'(mem_req), 0);
    chk("t1_ack_pulse", 32'(if_ack), 0);

    // 2: simultaneous requests, DM store first, IF in DM's ack cycle
    if_req = 1'b1; if_addr = 32'h0000_0200;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'hCAFE_F00D;
    sb_q.push_back('{1'b1, 32'h0100_FEFF});
    sb_q.push_back('{1'b0, 32'h0200_FDFF});
    tick();
    chk("t2_dm_sel", 32'(addr_sel), 1);
    chk("t2_dm_we", 32'(mem_we), 1);
    chk("t2_dm_addr", mem_addr, 32'h100);
    chk("t2_dm_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("t2_stall_if", 32'(stall_if), 1);
    tick();
    chk("t2_dm_ack", 32'(dm_ack), 1);
    chk("t2_stall_mem_ack", 32'(stall_mem), 0);
    tick();
    chk("t2_if_grant", 32'(mem_req), 1);
    chk("t2_if_sel", 32'(addr_sel), 0);
    chk("t2_if_addr", mem_addr, 32'h200);
    chk("t2_if_we", 32'(mem_we), 0);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk("t2_if_ack", 32'(if_ack), 1);
    tick();
    if_req = 1'b0;
    chk("t2_idle", 32'(mem_req), 0);

    // 3: load with 5 wait states; requester address changes mid-grant
    wait_cfg = 5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
    sb_q.push_back('{1'b1, 32'h0300_FCFF});
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t3_mem_req", 32'(mem_req), 1);
      chk("t3_mem_addr", mem_addr, 32'h300);
      chk("t3_stall_mem", 32'(stall_mem), 1);
      chk("t3_no_early_ack", 32'(dm_ack), 0);
      if (i == 2) dm_addr = 32'h0000_0999;
      tick();
    end
    chk("t3_dm_ack", 32'(dm_ack), 1);
    tick();
    dm_req = 1'b0;
    chk("t3_single_ack", 32'(dm_ack), 0);
    chk("t3_idle", 32'(mem_req), 0);
    wait_cfg = 0;

    // 4: memory never ready -> abort at grant+63 with zero data, sticky bus_err
    ready_en = 1'b0;
    dm_req = 1'b1; dm_addr = 32'h0000_0400;
    sb_q.push_back('{1'b1, 32'h0000_0000});
    tick();
    for (int i = 0; i < 63; i++) begin
      chk("t4_waiting", 32'(mem_req), 1);
      chk("t4_no_err_yet", 32'(bus_err), 0);
      tick();
    end
    chk("t4_dm_ack", 32'(dm_ack), 1);
    chk("t4_bus_err", 32'(bus_err), 1);
    chk("t4_dm_rdata", dm_rdata, 0);
    chk("t4_req_drop", 32'(mem_req), 0);
    tick();
    dm_req = 1'b0; ready_en = 1'b1;
    chk("t4_err_sticky", 32'(bus_err), 1);
    if_req = 1'b1; if_addr = 32'h0000_0040;
    sb_q.push_back('{1'b0, 32'h2008_0005});
    tick(); tick();
    chk("t4_if_after_err", 32'(if_ack), 1);
    chk("t4_err_sticky2", 32'(bus_err), 1);
    tick();
    if_req = 1'b0;

    // 5: reset during a DM wait abandons the transaction
    ready_en = 1'b0;
    dm_req = 1'b1; dm_addr = 32'h0000_0500;
    tick(); tick(); tick();
    chk("t5_waiting", 32'(mem_req), 1);
    rst = 1'b1;
    tick();
    chk("t5_mem_req", 32'(mem_req), 0);
    chk("t5_addr_sel", 32'(addr_sel), 0);
    chk("t5_no_ack", 32'(dm_ack), 0);
    chk("t5_bus_err_clr", 32'(bus_err), 0);
    chk("t5_dm_rdata", dm_rdata, 0);
    chk("t5_if_rdata", if_rdata, 0);
    dm_req = 1'b0; rst = 1'b0; ready_en = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    sb_q.push_back('{1'b0, 32'h2008_0005});
    tick();
    chk("t5_idle_regrant", 32'(mem_req), 1);
    tick();
    chk("t5_if_ack", 32'(if_ack), 1);
    tick();
    if_req = 1'b0;

    // 6: stray mem_ready while idle is ignored
    stray_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_req", 32'(mem_req), 0);
      chk("t6_no_ack", 32'(if_ack | dm_ack), 0);
    end
    stray_ready = 1'b0;

    // Back-to-back loads by DM: one grant every 3 cycles
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0600;
    sb_q.push_back('{1'b1, 32'h0600_F9FF});
    sb_q.push_back('{1'b1, 32'h0700_F8FF});
    tick();
    chk("b2b_g1", 32'(mem_req), 1);
    tick();
    chk("b2b_ack1", 32'(dm_ack), 1);
    tick();
    dm_addr = 32'h0000_0700;
    chk("b2b_gap", 32'(mem_req), 0);
    tick();
    chk("b2b_g2", 32'(mem_req), 1);
    chk("b2b_g2_addr", mem_addr, 32'h700);
    tick();
    chk("b2b_ack2", 32'(dm_ack), 1);
    tick();
    dm_req = 1'b0;
    tick(); tick();
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
